survivor_mem: RTL and testbench

- Survivor-path buffer sitting between the ACS array and the traceback stage of the Viterbi decoder.
- Stores one row of per-state back-pointers (previous-state vectors) per trellis step until TRACEBACK_DEPTH steps are collected.
- Selects the minimum-metric end node, then replays the rows newest-to-oldest, one per cycle, with the traceback enable, until traceback reports done.

---
 rtl/survivor_mem.sv | 152 +++++++++++++++
 tb/tb_survivor_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/survivor_mem.sv
// survivor_mem: survivor-path buffer between the ACS array and traceback.
//
// Collects TRACEBACK_DEPTH rows of per-state back-pointers. On the final
// write it latches the minimum-metric state as the traceback start node.
// It then replays the rows newest-to-oldest, one per cycle, until
// traceback signals completion.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_valid         - ACS row valid this cycle
//   o_ready         - a row is accepted this cycle (FILL only)
//   i_prv_st        - back-pointer per state, entry j at [j*STATE_REG_NUM +: STATE_REG_NUM]
//   i_path_metric   - path metric per state, entry j at [j*METRIC_W +: METRIC_W]
//   o_sel_node      - minimum-metric state of the last block's final step
//   o_bck_prv_st    - row being replayed (zero outside TRACE)
//   o_en_t          - traceback enable (TRACE)
//   i_decoder_done  - traceback finished the block (honoured in TRACE only)
//   o_busy          - high in any state other than FILL
//   o_drop_cnt      - saturating count of rows offered while not ready
//                     (present only when SURV_DROP_CNT_EN is defined)
module survivor_mem #(
  parameter int unsigned STATE_NUM       = 64,
  parameter int unsigned STATE_REG_NUM   = 6,
  parameter int unsigned TRACEBACK_DEPTH = 32,
  parameter int unsigned METRIC_W        = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [STATE_NUM*STATE_REG_NUM-1:0] i_prv_st,
  input  logic [STATE_NUM*METRIC_W-1:0]      i_path_metric,
  output logic [STATE_REG_NUM-1:0]           o_sel_node,
  output logic [STATE_NUM*STATE_REG_NUM-1:0] o_bck_prv_st,
  output logic                               o_en_t,
  input  logic                               i_decoder_done,
  output logic                               o_busy
`ifdef SURV_DROP_CNT_EN
  ,
  output logic [15:0]                        o_drop_cnt
`endif
);

  localparam int unsigned ROW_W = STATE_NUM * STATE_REG_NUM;
  localparam int unsigned PTR_W = (TRACEBACK_DEPTH > 1) ? $clog2(TRACEBACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(TRACEBACK_DEPTH - 1);

  typedef enum logic [1:0] {
    FILL,
    SELECT,
    TRACE,
    DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [STATE_REG_NUM-1:0] sel_q, sel_d;
  logic                     mem_we;
  logic [ROW_W-1:0]         mem_q [TRACEBACK_DEPTH];

  logic [METRIC_W-1:0]      min_val;
  logic [STATE_REG_NUM-1:0] min_idx;

  // Argmin over the current step's metrics; strict '<' keeps the lowest
  // index on ties.
  always_comb begin
    min_val = i_path_metric[0 +: METRIC_W];
    min_idx = '0;
    for (int unsigned j = 1; j < STATE_NUM; j++) begin
      if (i_path_metric[j*METRIC_W +: METRIC_W] < min_val) begin
        min_val = i_path_metric[j*METRIC_W +: METRIC_W];
        min_idx = STATE_REG_NUM'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sel_d    = sel_q;
    mem_we   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (i_valid) begin
          mem_we = 1'b1;
          if (wr_ptr_q == LAST) begin
            wr_ptr_d = '0;
            sel_d    = min_idx;
            state_d  = SELECT;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      SELECT: begin
        rd_ptr_d = LAST;
        state_d  = TRACE;
      end
      TRACE: begin
        // Hold on row 0 if traceback keeps running past the block.
        if (rd_ptr_q != '0) rd_ptr_d = rd_ptr_q - PTR_W'(1);
        if (i_decoder_done) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sel_q    <= sel_d;
    end
  end

  // Row storage has no reset; contents are only read after a full block.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_ptr_q] <= i_prv_st;
  end

  assign o_ready      = (state_q == FILL);
  assign o_busy       = (state_q != FILL);
  assign o_en_t       = (state_q == TRACE);
  assign o_sel_node   = sel_q;
  assign o_bck_prv_st = (state_q == TRACE) ? mem_q[rd_ptr_q] : '0;

`ifdef SURV_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (i_valid && !o_ready && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_survivor_mem.sv
module tb_survivor_mem;

  localparam int unsigned SN    = 64;
  localparam int unsigned SRN   = 6;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned MW    = 8;
  localparam int unsigned ROW_W = SN * SRN;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               o_ready;
  logic [ROW_W-1:0]   i_prv_st;
  logic [SN*MW-1:0]   i_path_metric;
  logic [SRN-1:0]     o_sel_node;
  logic [ROW_W-1:0]   o_bck_prv_st;
  logic               o_en_t;
  logic               i_decoder_done;
  logic               o_busy;
`ifdef SURV_DROP_CNT_EN
  logic [15:0]        o_drop_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_drops = 0;

  survivor_mem #(
    .STATE_NUM       (SN),
    .STATE_REG_NUM   (SRN),
    .TRACEBACK_DEPTH (DEPTH),
    .METRIC_W        (MW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_prv_st       (i_prv_st),
    .i_path_metric  (i_path_metric),
    .o_sel_node     (o_sel_node),
    .o_bck_prv_st   (o_bck_prv_st),
    .o_en_t         (o_en_t),
    .i_decoder_done (i_decoder_done),
    .o_busy         (o_busy)
`ifdef SURV_DROP_CNT_EN
    ,
    .o_drop_cnt     (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int unsigned off;          // row s entry j = (s+j+off) mod 64
    int unsigned a, b;         // states given metric lo at the final step
    int unsigned lo, hi;
    bit          gap;          // idle cycle between accepted rows
    bit          bp;           // hold i_valid high with garbage through SELECT..DRAIN
    int unsigned trace_cycles; // done raised in this TRACE cycle
    int unsigned exp_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] mkrow(input int unsigned s, input int unsigned off);
    logic [ROW_W-1:0] r;
    for (int unsigned j = 0; j < SN; j++) r[j*SRN +: SRN] = SRN'((s + j + off) % SN);
    return r;
  endfunction

  function automatic logic [SN*MW-1:0] mkmet(input vec_t v, input bit final_step);
    logic [SN*MW-1:0] m;
    for (int unsigned j = 0; j < SN; j++) begin
      if (final_step) m[j*MW +: MW] = MW'((j == v.a || j == v.b) ? v.lo : v.hi);
      else            m[j*MW +: MW] = MW'((j == SN - 1) ? 0 : 200);
    end
    return m;
  endfunction

  task automatic chk_drops();
`ifdef SURV_DROP_CNT_EN
    chk("drop_cnt", 64'(o_drop_cnt), 64'(exp_drops));
`endif
  endtask

  // Writes DEPTH rows; returns positioned in the SELECT cycle.
  task automatic fill(input vec_t v);
    for (int unsigned s = 0; s < DEPTH; s++) begin
      chk("ready_fill", 64'(o_ready), 64'd1);
      i_valid        = 1'b1;
      i_prv_st       = mkrow(s, v.off);
      i_path_metric  = mkmet(v, s == DEPTH - 1);
      i_decoder_done = 1'b0;
      step();
      if (v.gap && s < DEPTH - 1) begin
        i_valid        = 1'b0;
        i_prv_st       = '1;
        i_path_metric  = '0;
        i_decoder_done = 1'b1;   // must be ignored outside TRACE
        chk("ready_gap", 64'(o_ready), 64'd1);
        step();
        i_decoder_done = 1'b0;
      end
    end
    i_valid  = v.bp;
    i_prv_st = '1;
  endtask

  task automatic run_block(input vec_t v);
    int unsigned st;
    fill(v);
    chk("sel_node", 64'(o_sel_node), 64'(v.exp_sel));
    chk("select_ready", 64'(o_ready), 64'd0);
    chk("select_en_t", 64'(o_en_t), 64'd0);
    chk("select_busy", 64'(o_busy), 64'd1);
    chk_row("select_row", o_bck_prv_st, '0);
    step();
    for (int unsigned k = 0; k < v.trace_cycles; k++) begin
      st = (k < DEPTH) ? (DEPTH - 1 - k) : 0;
      chk("trace_en_t", 64'(o_en_t), 64'd1);
      chk("trace_ready", 64'(o_ready), 64'd0);
      chk_row("trace_row", o_bck_prv_st, mkrow(st, v.off));
      if (k == v.trace_cycles - 1) i_decoder_done = 1'b1;
      step();
    end
    i_decoder_done = 1'b0;
    chk("drain_en_t", 64'(o_en_t), 64'd0);
    chk("drain_ready", 64'(o_ready), 64'd0);
    chk("drain_busy", 64'(o_busy), 64'd1);
    chk_row("drain_row", o_bck_prv_st, '0);
    step();
    if (v.bp) exp_drops += 1 + v.trace_cycles + 1;
    chk("post_ready", 64'(o_ready), 64'd1);
    chk("post_busy", 64'(o_busy), 64'd0);
    chk("sel_hold", 64'(o_sel_node), 64'(v.exp_sel));
    chk_drops();
    i_valid = 1'b0;
  endtask

  initial begin
    //          off a   b   lo  hi   gap bp  tc  exp
    vecs[0] = '{0,  5,  5,  0,  10,  0,  0,  32, 5};   // basic fill and replay
    vecs[1] = '{7,  0,  0,  60, 60,  0,  0,  32, 0};   // all metrics tie
    vecs[2] = '{13, 9,  40, 7,  20,  1,  0,  32, 9};   // two-way tie, gapped input
    vecs[3] = '{21, 63, 63, 1,  2,   0,  1,  32, 63};  // backpressure through replay
    vecs[4] = '{3,  40, 41, 0,  255, 1,  1,  32, 40};  // gapped plus backpressure
    vecs[5] = '{50, 17, 17, 3,  4,   0,  0,  40, 17};  // late done: saturate on row 0

    rst = 1'b1;
    i_valid = 1'b0;
    i_prv_st = '0;
    i_path_metric = '0;
    i_decoder_done = 1'b0;
    step();
    step();
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_en_t", 64'(o_en_t), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_sel", 64'(o_sel_node), 64'd0);
    chk_row("rst_row", o_bck_prv_st, '0);
    chk_drops();
    rst = 1'b0;

    for (int unsigned i = 0; i < 6; i++) run_block(vecs[i]);

    // Reset in the 10th TRACE cycle, then a clean block.
    fill(vecs[0]);
    chk("rs_sel", 64'(o_sel_node), 64'd5);
    step();
    for (int unsigned k = 0; k < 10; k++) begin
      chk_row("rs_trace_row", o_bck_prv_st, mkrow(DEPTH - 1 - k, 0));
      if (k == 9) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    exp_drops = 0;
    chk("rs_en_t", 64'(o_en_t), 64'd0);
    chk("rs_ready", 64'(o_ready), 64'd1);
    chk("rs_busy", 64'(o_busy), 64'd0);
    chk("rs_sel_clr", 64'(o_sel_node), 64'd0);
    chk_row("rs_row", o_bck_prv_st, '0);
    chk_drops();
    run_block(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
